// File: rtl/ttc_pkg.sv
// rtl/ttc_pkg.sv - shared TTC constants, L1A mode and resync FSM encodings
package ttc_pkg;

  localparam int MXBXN     = 12;
  localparam int LHC_CYCLE = 3564;
  localparam int MXCNT     = 32;

  localparam logic [MXBXN-1:0] BXN_LAST = MXBXN'(LHC_CYCLE - 1);

  typedef enum logic [1:0] {
    L1A_OFF      = 2'd0,
    L1A_SINGLE   = 2'd1,
    L1A_PERIODIC = 2'd2,
    L1A_RSVD     = 2'd3
  } l1a_mode_e;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_PEND = 2'd1,
    RS_FIRE = 2'd2,
    RS_HOLD = 2'd3
  } resync_state_e;

  function automatic logic [MXCNT-1:0] sat_inc(input logic [MXCNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ttc_l1a_gen.sv
// rtl/ttc_l1a_gen.sv - L1A candidate generation, min-gap/holdoff blocking, sent/dropped/done counters
module ttc_l1a_gen
  import ttc_pkg::*;
#(
  parameter int MXINT       = 16,
  parameter int L1A_MIN_GAP = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [1:0]       l1a_mode_i,
  input  logic             l1a_req_i,
  input  logic [MXINT-1:0] l1a_interval_i,
  input  logic [MXCNT-1:0] l1a_ntrig_i,
  input  logic             block_i,
  input  logic             clear_i,
  output logic             l1a_o,
  output logic [MXCNT-1:0] sent_o,
  output logic [MXCNT-1:0] dropped_o,
  output logic             done_o
);

  localparam int GW = $clog2(L1A_MIN_GAP + 1);

  logic [1:0]       mode_q;
  logic [MXINT-1:0] icnt_q, icnt_d, icnt_last;
  logic [GW-1:0]    gap_q, gap_d;
  logic [MXCNT-1:0] sent_q, sent_d, drop_q, drop_d;
  logic             done_q, done_d, l1a_q, l1a_d;
  logic             mode_chg, periodic, reached, icnt_tc, cand, blocked;

  always_comb begin
    mode_chg  = (l1a_mode_i != mode_q);
    periodic  = (mode_q == L1A_PERIODIC);
    reached   = (l1a_ntrig_i != '0) && (sent_q >= l1a_ntrig_i);
    icnt_last = (l1a_interval_i == '0) ? '0 : l1a_interval_i - 1'b1;
    icnt_tc   = (icnt_q >= icnt_last);
    // Candidates are suppressed on a mode-change cycle so the cleared sent count stays consistent
    cand      = enable_i && !mode_chg &&
                (((mode_q == L1A_SINGLE) && l1a_req_i) || (periodic && icnt_tc && !reached));
    blocked   = (gap_q != '0) || block_i;
    l1a_d     = cand && !blocked;
    gap_d     = l1a_d ? GW'(L1A_MIN_GAP - 1) : ((gap_q != '0) ? gap_q - 1'b1 : gap_q);
    icnt_d    = (periodic && !reached) ? (icnt_tc ? '0 : icnt_q + 1'b1) : '0;
    sent_d    = l1a_d ? sat_inc(sent_q) : sent_q;
    drop_d    = (cand && blocked) ? sat_inc(drop_q) : drop_q;
    done_d    = done_q || (periodic && reached);
    if (!enable_i) begin
      icnt_d = '0;
      done_d = 1'b0;
    end
    if (clear_i) begin
      icnt_d = '0;
      sent_d = '0;
      drop_d = '0;
      done_d = 1'b0;
    end
    if (mode_chg) begin
      icnt_d = '0;
      sent_d = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= '0;
      icnt_q <= '0;
      gap_q  <= '0;
      sent_q <= '0;
      drop_q <= '0;
      done_q <= 1'b0;
      l1a_q  <= 1'b0;
    end else begin
      mode_q <= l1a_mode_i;
      icnt_q <= icnt_d;
      gap_q  <= gap_d;
      sent_q <= sent_d;
      drop_q <= drop_d;
      done_q <= done_d;
      l1a_q  <= l1a_d;
    end
  end

  assign l1a_o     = l1a_q;
  assign sent_o    = sent_q;
  assign dropped_o = drop_q;
  assign done_o    = done_q;

endmodule

// File: rtl/ttc_generator.sv
// rtl/ttc_generator.sv - local TTC source: bunch counter, bx0, resync FSM and L1A generator
module ttc_generator
  import ttc_pkg::*;
#(
  parameter int MXINT          = 16,
  parameter int L1A_MIN_GAP    = 3,
  parameter int RESYNC_HOLDOFF = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [MXBXN-1:0] bx0_bxn,
  input  logic             resync_req,
  input  logic [1:0]       l1a_mode,
  input  logic             l1a_req,
  input  logic [MXINT-1:0] l1a_interval,
  input  logic [MXCNT-1:0] l1a_ntrig,
  output logic             ttc_bx0,
  output logic             ttc_resync,
  output logic             ttc_l1a,
  output logic [MXBXN-1:0] gen_bxn,
  output logic [MXCNT-1:0] orbit_count,
  output logic [MXCNT-1:0] l1a_sent,
  output logic [MXCNT-1:0] l1a_dropped,
  output logic             resync_pending,
  output logic             l1a_done
);

  localparam int HW = $clog2(RESYNC_HOLDOFF + 1);

  resync_state_e    state_q, state_d;
  logic [MXBXN-1:0] bxn_q, bxn_d, lim_q, lim_d, lim_prev;
  logic [MXCNT-1:0] orbit_q, orbit_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             rearm_q, rearm_d, bx0_q, bx0_d, resync_q, resync_d, wrap;

  // Strobes are registered from next-state values so they line up with gen_bxn
  always_comb begin
    lim_d    = (bx0_bxn >= BXN_LAST) ? BXN_LAST : bx0_bxn;
    lim_prev = (lim_q == '0) ? BXN_LAST : lim_q - 1'b1;
    wrap     = enable && (bxn_q >= BXN_LAST);
    bxn_d    = (!enable || wrap) ? '0 : bxn_q + 1'b1;
    orbit_d  = wrap ? sat_inc(orbit_q) : orbit_q;
    state_d  = state_q;
    hold_d   = hold_q;
    rearm_d  = rearm_q;
    case (state_q)
      RS_IDLE: if (resync_req) state_d = RS_PEND;
      RS_PEND: if (bxn_d == lim_prev) state_d = RS_FIRE;
      RS_FIRE: begin
        state_d = RS_HOLD;
        hold_d  = '0;
        orbit_d = '0;
      end
      RS_HOLD: begin
        if (resync_req) rearm_d = 1'b1;
        if (hold_q == HW'(RESYNC_HOLDOFF - 1)) begin
          state_d = (rearm_q || resync_req) ? RS_PEND : RS_IDLE;
          rearm_d = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = RS_IDLE;
    endcase
    if (!enable) begin
      state_d = RS_IDLE;
      hold_d  = '0;
      rearm_d = 1'b0;
    end
    resync_d = (state_d == RS_FIRE);
    bx0_d    = enable && (bxn_d == lim_q) && !resync_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RS_IDLE;
      bxn_q    <= '0;
      lim_q    <= '0;
      orbit_q  <= '0;
      hold_q   <= '0;
      rearm_q  <= 1'b0;
      bx0_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bxn_q    <= bxn_d;
      lim_q    <= lim_d;
      orbit_q  <= orbit_d;
      hold_q   <= hold_d;
      rearm_q  <= rearm_d;
      bx0_q    <= bx0_d;
      resync_q <= resync_d;
    end
  end

  ttc_l1a_gen #(
    .MXINT       (MXINT),
    .L1A_MIN_GAP (L1A_MIN_GAP)
  ) u_l1a_gen (
    .clock          (clock),
    .reset          (reset),
    .enable_i       (enable),
    .l1a_mode_i     (l1a_mode),
    .l1a_req_i      (l1a_req),
    .l1a_interval_i (l1a_interval),
    .l1a_ntrig_i    (l1a_ntrig),
    .block_i        ((state_q == RS_FIRE) || (state_q == RS_HOLD) || resync_q),
    .clear_i        (state_q == RS_FIRE),
    .l1a_o          (ttc_l1a),
    .sent_o         (l1a_sent),
    .dropped_o      (l1a_dropped),
    .done_o         (l1a_done)
  );

  assign ttc_bx0        = bx0_q;
  assign ttc_resync     = resync_q;
  assign gen_bxn        = bxn_q;
  assign orbit_count    = orbit_q;
  assign resync_pending = (state_q == RS_PEND) || rearm_q;

endmodule

// File: tb/tb_ttc_generator.sv
// tb/tb_ttc_generator.sv - directed self-checking bench for ttc_generator
module tb_ttc_generator;
  import ttc_pkg::*;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [MXBXN-1:0] bx0_bxn = '0;
  logic             resync_req = 1'b0;
  logic [1:0]       l1a_mode = 2'd0;
  logic             l1a_req = 1'b0;
  logic [15:0]      l1a_interval = '0;
  logic [MXCNT-1:0] l1a_ntrig = '0;
  logic             ttc_bx0, ttc_resync, ttc_l1a, resync_pending, l1a_done;
  logic [MXBXN-1:0] gen_bxn;
  logic [MXCNT-1:0] orbit_count, l1a_sent, l1a_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  ttc_generator dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .bx0_bxn        (bx0_bxn),
    .resync_req     (resync_req),
    .l1a_mode       (l1a_mode),
    .l1a_req        (l1a_req),
    .l1a_interval   (l1a_interval),
    .l1a_ntrig      (l1a_ntrig),
    .ttc_bx0        (ttc_bx0),
    .ttc_resync     (ttc_resync),
    .ttc_l1a        (ttc_l1a),
    .gen_bxn        (gen_bxn),
    .orbit_count    (orbit_count),
    .l1a_sent       (l1a_sent),
    .l1a_dropped    (l1a_dropped),
    .resync_pending (resync_pending),
    .l1a_done       (l1a_done)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_strobe(input string tag, input bit want_resync, input int limit, output int n);
    n = 1;
    tick();
    while (!(want_resync ? ttc_resync : ttc_bx0) && n < limit) begin
      tick();
      n++;
    end
    check_eq({tag, "_seen"}, 64'(want_resync ? ttc_resync : ttc_bx0), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_bxn"}, 64'(gen_bxn), 64'd0);
    check_eq({tag, "_strobes"}, 64'({ttc_bx0, ttc_resync, ttc_l1a}), 64'd0);
    check_eq({tag, "_orbit"}, 64'(orbit_count), 64'd0);
    check_eq({tag, "_sent"}, 64'(l1a_sent), 64'd0);
    check_eq({tag, "_dropped"}, 64'(l1a_dropped), 64'd0);
    check_eq({tag, "_flags"}, 64'({resync_pending, l1a_done}), 64'd0);
  endtask

  initial begin
    int n, cnt, first_k, last_k;
    logic done_mid;

    // reset state
    bx0_bxn = 12'd100;
    repeat (3) tick();
    check_all_zero("reset");

    // bx0 placement and orbit period
    reset = 1'b0;
    enable = 1'b1;
    wait_strobe("bx0_first", 1'b0, 4000, n);
    check_eq("bx0_first_bxn", 64'(gen_bxn), 64'd100);
    wait_strobe("bx0_second", 1'b0, 4000, n);
    check_eq("bx0_period", 64'(n), 64'd3564);
    check_eq("bx0_second_bxn", 64'(gen_bxn), 64'd100);
    check_eq("orbit_after_wrap", 64'(orbit_count), 64'd1);

    // out-of-range offset clamps to the last bunch
    bx0_bxn = 12'd4000;
    wait_strobe("bx0_clamp", 1'b0, 4000, n);
    check_eq("bx0_clamp_bxn", 64'(gen_bxn), 64'd3563);

    // resync with offset 0 fires at 3563, bx0 follows
    bx0_bxn = 12'd0;
    resync_req = 1'b1;
    tick();
    resync_req = 1'b0;
    check_eq("pend0_flag", 64'(resync_pending), 64'd1);
    wait_strobe("resync0", 1'b1, 4000, n);
    check_eq("resync0_bxn", 64'(gen_bxn), 64'd3563);
    check_eq("resync0_no_bx0", 64'(ttc_bx0), 64'd0);
    tick();
    check_eq("resync0_bx0_next", 64'(ttc_bx0), 64'd1);
    check_eq("resync0_bxn_next", 64'(gen_bxn), 64'd0);
    check_eq("resync0_orbit_clr", 64'(orbit_count), 64'd0);

    // single L1A outside holdoff
    repeat (20) tick();
    l1a_mode = 2'd1;
    tick();
    l1a_req = 1'b1;
    tick();
    l1a_req = 1'b0;
    check_eq("single_l1a", 64'(ttc_l1a), 64'd1);
    check_eq("single_sent", 64'(l1a_sent), 64'd1);

    // resync at bxn 10 with offset 200, second request during PEND ignored
    bx0_bxn = 12'd200;
    n = 0;
    while (!(orbit_count == 1 && gen_bxn == 10) && n < 8000) begin
      tick();
      n++;
    end
    check_eq("reach_bxn10", 64'(gen_bxn), 64'd10);
    resync_req = 1'b1;
    tick();
    resync_req = 1'b0;
    check_eq("pend200_flag", 64'(resync_pending), 64'd1);
    resync_req = 1'b1;
    tick();
    resync_req = 1'b0;
    wait_strobe("resync200", 1'b1, 4000, n);
    check_eq("resync200_bxn", 64'(gen_bxn), 64'd199);
    check_eq("resync200_no_bx0", 64'(ttc_bx0), 64'd0);
    tick();
    check_eq("resync200_bx0_next", 64'(ttc_bx0), 64'd1);
    check_eq("resync200_bxn_next", 64'(gen_bxn), 64'd200);
    check_eq("resync200_orbit_clr", 64'(orbit_count), 64'd0);
    check_eq("resync200_sent_clr", 64'(l1a_sent), 64'd0);
    check_eq("resync200_not_pend", 64'(resync_pending), 64'd0);

    // L1A request 4 clocks after resync lands in holdoff
    repeat (3) tick();
    l1a_req = 1'b1;
    tick();
    l1a_req = 1'b0;
    check_eq("hold_l1a_blocked", 64'(ttc_l1a), 64'd0);
    check_eq("hold_dropped", 64'(l1a_dropped), 64'd1);
    cnt = 0;
    for (int k = 0; k < 3700; k++) begin
      tick();
      if (ttc_resync) cnt++;
    end
    check_eq("ignored_req_no_resync", 64'(cnt), 64'd0);

    // periodic interval 1 under a 3-clock min gap
    l1a_interval = 16'd1;
    l1a_ntrig = '0;
    l1a_mode = 2'd2;
    tick();
    for (int k = 1; k <= 30; k++) begin
      tick();
      check_eq($sformatf("per1_l1a_k%0d", k), 64'(ttc_l1a), 64'((k % 3) == 1));
    end
    check_eq("per1_sent", 64'(l1a_sent), 64'd10);
    check_eq("per1_dropped", 64'(l1a_dropped), 64'd21);

    // periodic interval 10, stop after 5
    l1a_mode = 2'd0;
    tick();
    l1a_interval = 16'd10;
    l1a_ntrig = 32'd5;
    l1a_mode = 2'd2;
    tick();
    cnt = 0;
    first_k = 0;
    last_k = 0;
    done_mid = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (k == 45) done_mid = l1a_done;
      if (ttc_l1a) begin
        cnt++;
        if (first_k == 0) first_k = k;
        last_k = k;
      end
    end
    check_eq("per10_count", 64'(cnt), 64'd5);
    check_eq("per10_first", 64'(first_k), 64'd10);
    check_eq("per10_last", 64'(last_k), 64'd50);
    check_eq("per10_done_mid", 64'(done_mid), 64'd0);
    check_eq("per10_done", 64'(l1a_done), 64'd1);
    check_eq("per10_sent", 64'(l1a_sent), 64'd5);
    check_eq("per10_dropped", 64'(l1a_dropped), 64'd21);

    // disable holds bunch counter, clears done, keeps counters
    enable = 1'b0;
    tick();
    check_eq("dis_bxn", 64'(gen_bxn), 64'd0);
    check_eq("dis_done", 64'(l1a_done), 64'd0);
    check_eq("dis_sent_kept", 64'(l1a_sent), 64'd5);

    // reset during PEND
    enable = 1'b1;
    l1a_mode = 2'd0;
    resync_req = 1'b1;
    tick();
    resync_req = 1'b0;
    check_eq("pend_before_reset", 64'(resync_pending), 64'd1);
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("reset_in_pend");
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3700; k++) begin
      tick();
      if (ttc_resync) cnt++;
    end
    check_eq("reset_pend_no_resync", 64'(cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
